dmem_arbiter: RTL and testbench

//  Shares the single-port data memory between two requesters: port 0 (core load/store) and port 1 (debug/loader).

---
 rtl/dmem_arbiter.sv | 148 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: fixed priority to port 0 with a
// port-1 starvation guard, address error checking, and a zero-fill clear sequencer.
module dmem_arbiter #(
  parameter int unsigned DEPTH        = 256,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [31:0]       p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [31:0]       p0_rdata,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [31:0]       p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [31:0]       p1_rdata,
  output logic              p1_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {ARB, CLEAR, DONE} state_t;

  state_t           state;
  logic [IDX_W-1:0] clr_idx;
  logic [CNT_W-1:0] starve_cnt;

  logic             arb_ok;
  logic             force_p1;
  logic             err0;
  logic             err1;
  logic             sel_we;
  logic             sel_err;

  // Misaligned or beyond the last word.
  function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
    return (a[1:0] != 2'b00) || (a[ADDR_W-1:2] >= (ADDR_W-2)'(DEPTH));
  endfunction

  assign err0     = addr_bad(p0_addr);
  assign err1     = addr_bad(p1_addr);
  assign arb_ok   = (state == ARB) && !clr_start;
  assign force_p1 = p1_req && (starve_cnt == CNT_W'(STARVE_LIMIT));
  assign p1_gnt   = arb_ok && p1_req && (!p0_req || force_p1);
  assign p0_gnt   = arb_ok && p0_req && !p1_gnt;
  assign clr_busy = (state == CLEAR);
  assign clr_done = (state == DONE);

  // Memory drive: granted port in ARB, zero-fill writes in CLEAR.
  always_comb begin
    sel_we    = 1'b0;
    sel_err   = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (p0_gnt) begin
      sel_we    = p0_we;
      sel_err   = err0;
      mem_addr  = p0_addr;
      mem_wdata = p0_wdata;
    end else if (p1_gnt) begin
      sel_we    = p1_we;
      sel_err   = err1;
      mem_addr  = p1_addr;
      mem_wdata = p1_wdata;
    end
    if (p0_gnt || p1_gnt) begin
      mem_read  = !sel_we && !sel_err;
      mem_write = sel_we && !sel_err;
    end
    if (state == CLEAR) begin
      mem_write = 1'b1;
      mem_addr  = ADDR_W'(clr_idx) << 2;
      mem_wdata = '0;
    end
  end

  // State, clear index, starvation counter and registered responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB;
      clr_idx    <= '0;
      starve_cnt <= '0;
      p0_rvalid  <= 1'b0;
      p0_rdata   <= '0;
      p0_err     <= 1'b0;
      p1_rvalid  <= 1'b0;
      p1_rdata   <= '0;
      p1_err     <= 1'b0;
    end else begin
      case (state)
        ARB: begin
          if (clr_start) begin
            state   <= CLEAR;
            clr_idx <= '0;
          end
        end
        CLEAR: begin
          if (clr_idx == IDX_W'(DEPTH - 1)) begin
            state   <= DONE;
            clr_idx <= '0;
          end else begin
            clr_idx <= clr_idx + IDX_W'(1);
          end
        end
        DONE: begin
          state   <= ARB;
          clr_idx <= '0;
        end
        default: state <= ARB;
      endcase

      if ((state == ARB) && clr_start) begin
        starve_cnt <= '0;
      end else if (p1_req && !p1_gnt) begin
        if (starve_cnt != CNT_W'(STARVE_LIMIT)) starve_cnt <= starve_cnt + CNT_W'(1);
      end else begin
        starve_cnt <= '0;
      end

      p0_rvalid <= p0_gnt;
      p0_err    <= p0_gnt && err0;
      p0_rdata  <= (p0_gnt && !p0_we && !err0) ? mem_rdata : 32'h0;
      p1_rvalid <= p1_gnt;
      p1_err    <= p1_gnt && err1;
      p1_rdata  <= (p1_gnt && !p1_we && !err1) ? mem_rdata : 32'h0;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 256-word memory behind it.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr_start;
  logic        clr_busy, clr_done;
  logic        p0_req, p0_we, p0_gnt, p0_rvalid, p0_err;
  logic [31:0] p0_addr, p0_wdata, p0_rdata;
  logic        p1_req, p1_we, p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p1_addr, p1_wdata, p1_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [256];
  int          n_vec  = 0;
  int          n_miss = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DEPTH(256), .ADDR_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .clr_start(clr_start),
    .clr_busy(clr_busy), .clr_done(clr_done),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory model: combinational read, write on clock, zeroed by its own reset.
  assign mem_rdata = mem[mem_addr[9:2]];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 256; k++) mem[k] <= 32'h0;
    end else if (mem_write) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; clr_start = 1'b0;
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
    repeat (2) mid();
    check("rst_p0_gnt", 32'(p0_gnt), 0);
    check("rst_p1_gnt", 32'(p1_gnt), 0);
    check("rst_mem_write", 32'(mem_write), 0);
    check("rst_mem_read", 32'(mem_read), 0);
    check("rst_clr_busy", 32'(clr_busy), 0);
    check("rst_clr_done", 32'(clr_done), 0);
    check("rst_p0_rvalid", 32'(p0_rvalid), 0);
    check("rst_mem_addr", mem_addr, 0);
    rst_n = 1'b1;

    // Port-0 write then read.
    nxt();
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h10; p0_wdata = 32'hDEADBEEF;
    mid();
    check("wr_gnt", 32'(p0_gnt), 1);
    check("wr_mem_write", 32'(mem_write), 1);
    check("wr_mem_addr", mem_addr, 32'h10);
    check("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
    nxt();
    p0_we = 1'b0; p0_wdata = '0;
    mid();
    check("rd_gnt", 32'(p0_gnt), 1);
    check("rd_mem_read", 32'(mem_read), 1);
    check("wr_rvalid", 32'(p0_rvalid), 1);
    check("wr_rdata", p0_rdata, 0);
    nxt();
    p0_req = 1'b0;
    mid();
    check("rd_rvalid", 32'(p0_rvalid), 1);
    check("rd_rdata", p0_rdata, 32'hDEADBEEF);
    check("rd_err", 32'(p0_err), 0);
    nxt();
    mid();
    check("idle_rvalid", 32'(p0_rvalid), 0);
    check("idle_rdata", p0_rdata, 0);

    // Contention: p1 wins every fifth cycle.
    nxt();
    p0_req = 1'b1; p0_addr = 32'h0;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h4;
    for (int i = 0; i < 10; i++) begin
      mid();
      check($sformatf("cont_p0_%0d", i), 32'(p0_gnt), 32'((i % 5) != 4));
      check($sformatf("cont_p1_%0d", i), 32'(p1_gnt), 32'((i % 5) == 4));
      nxt();
    end
    p0_req = 1'b0; p1_req = 1'b0;

    // Port-1 errors: misaligned, then out of range.
    p1_req = 1'b1; p1_addr = 32'h13;
    mid();
    check("e1_gnt", 32'(p1_gnt), 1);
    check("e1_mem_read", 32'(mem_read), 0);
    nxt();
    p1_addr = 32'h400;
    mid();
    check("e2_gnt", 32'(p1_gnt), 1);
    check("e2_mem_read", 32'(mem_read), 0);
    check("e1_rvalid", 32'(p1_rvalid), 1);
    check("e1_err", 32'(p1_err), 1);
    check("e1_rdata", p1_rdata, 0);
    nxt();
    p1_req = 1'b0; p1_addr = '0;
    mid();
    check("e2_rvalid", 32'(p1_rvalid), 1);
    check("e2_err", 32'(p1_err), 1);
    check("e2_rdata", p1_rdata, 0);
    nxt();
    mid();
    check("e_idle_err", 32'(p1_err), 0);

    // Preload all words nonzero.
    nxt();
    p0_req = 1'b1; p0_we = 1'b1;
    for (int i = 0; i < 256; i++) begin
      p0_addr = 32'(i) << 2; p0_wdata = 32'(i) + 32'h100;
      nxt();
    end
    check("preload_3fc", mem[255], 32'h1FF);

    // Clear with p0 requesting.
    p0_we = 1'b0; p0_addr = 32'h3FC; p0_wdata = '0; clr_start = 1'b1;
    mid();
    check("cs_p0_gnt", 32'(p0_gnt), 0);
    check("cs_p1_gnt", 32'(p1_gnt), 0);
    check("cs_mem_write", 32'(mem_write), 0);
    nxt();
    clr_start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mid();
      check($sformatf("clr_busy_%0d", i), 32'(clr_busy), 1);
      check($sformatf("clr_we_%0d", i), 32'(mem_write), 1);
      check($sformatf("clr_addr_%0d", i), mem_addr, 32'(i) << 2);
      check($sformatf("clr_wd_%0d", i), mem_wdata, 0);
      check($sformatf("clr_gnt_%0d", i), 32'(p0_gnt), 0);
      nxt();
    end
    mid();
    check("done_pulse", 32'(clr_done), 1);
    check("done_busy", 32'(clr_busy), 0);
    check("done_gnt", 32'(p0_gnt), 0);
    check("done_mem_write", 32'(mem_write), 0);
    nxt();
    mid();
    check("post_done", 32'(clr_done), 0);
    check("post_gnt", 32'(p0_gnt), 1);
    check("post_mem_read", 32'(mem_read), 1);
    nxt();
    p0_req = 1'b0;
    mid();
    check("post_rvalid", 32'(p0_rvalid), 1);
    check("post_rdata", p0_rdata, 0);
    check("mem_word0", mem[0], 0);

    // Reset in the middle of a clear.
    nxt();
    clr_start = 1'b1;
    nxt();
    clr_start = 1'b0;
    repeat (100) nxt();
    mid();
    check("mid_addr", mem_addr, 32'd400);
    check("mid_busy", 32'(clr_busy), 1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(clr_busy), 0);
    check("abort_mem_write", 32'(mem_write), 0);
    check("abort_mem_addr", mem_addr, 0);
    nxt();
    mid();
    rst_n = 1'b1;
    nxt();
    p0_req = 1'b1; p0_addr = 32'h3FC;
    mid();
    check("rr_gnt", 32'(p0_gnt), 1);
    check("rr_mem_read", 32'(mem_read), 1);
    check("rr_busy", 32'(clr_busy), 0);
    nxt();
    p0_req = 1'b0;
    mid();
    check("rr_rvalid", 32'(p0_rvalid), 1);
    check("rr_rdata", p0_rdata, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
